hex2seg_dual: RTL and testbench

//   Decodes a 4-bit hex nibble into 7-segment glyphs for two identical display digits (A and B).

---
 rtl/hex2seg_pkg.sv | 43 ++++
 rtl/hex2seg_dual_lut.sv | 45 ++++
 rtl/hex2seg_dual.sv | 50 +++++
 tb/tb_hex2seg_dual.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/hex2seg_pkg.sv
//==============================================================================
// Module      : hex2seg_pkg
// Description : Shared types, glyph table and polarity helper for the hex to
//               7-segment decoder.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package hex2seg_pkg;

    // Segment vector, bit order {a,b,c,d,e,f,g} (bit6 = a, bit0 = g)
    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK_AL = 7'h7F;

    // Glyphs stored active-low: a 0 bit lights the segment
    localparam seg7_t SEG_GLYPH_AL [16] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100,  // 9
        7'b0001000,  // A
        7'b1100000,  // b
        7'b0110001,  // C
        7'b1000010,  // d
        7'b0110000,  // E
        7'b0111000   // F
    };

    // Convert an active-low glyph to the requested pad polarity
    function automatic seg7_t to_polarity(input seg7_t seg_al, input bit active_low);
        return active_low ? seg_al : ~seg_al;
    endfunction

endpackage : hex2seg_pkg

`default_nettype wire

// File: rtl/hex2seg_dual_lut.sv
//==============================================================================
// Module      : hex7seg_lut
// Description : Combinational nibble to active-low 7-segment glyph lookup.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module hex7seg_lut
    import hex2seg_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg_al
);

    seg7_t w_seg_al;

    always_comb begin
        w_seg_al = SEG_BLANK_AL;
        case (i_hex)
            4'h0:    w_seg_al = SEG_GLYPH_AL[0];
            4'h1:    w_seg_al = SEG_GLYPH_AL[1];
            4'h2:    w_seg_al = SEG_GLYPH_AL[2];
            4'h3:    w_seg_al = SEG_GLYPH_AL[3];
            4'h4:    w_seg_al = SEG_GLYPH_AL[4];
            4'h5:    w_seg_al = SEG_GLYPH_AL[5];
            4'h6:    w_seg_al = SEG_GLYPH_AL[6];
            4'h7:    w_seg_al = SEG_GLYPH_AL[7];
            4'h8:    w_seg_al = SEG_GLYPH_AL[8];
            4'h9:    w_seg_al = SEG_GLYPH_AL[9];
            4'hA:    w_seg_al = SEG_GLYPH_AL[10];
            4'hB:    w_seg_al = SEG_GLYPH_AL[11];
            4'hC:    w_seg_al = SEG_GLYPH_AL[12];
            4'hD:    w_seg_al = SEG_GLYPH_AL[13];
            4'hE:    w_seg_al = SEG_GLYPH_AL[14];
            4'hF:    w_seg_al = SEG_GLYPH_AL[15];
            // Unknown nibble (X/Z in simulation) shows a blank digit
            default: w_seg_al = SEG_BLANK_AL;
        endcase
    end

    assign o_seg_al = w_seg_al;

endmodule : hex7seg_lut

`default_nettype wire

// File: rtl/hex2seg_dual.sv
//==============================================================================
// Module      : hex2seg_dual
// Description : Registered hex to 7-segment decoder driving two identical digits.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module hex2seg_dual
    import hex2seg_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] hex,
    output logic [6:0] seg_a,
    output logic [6:0] seg_b
);

    localparam seg7_t c_blank = to_polarity(SEG_BLANK_AL, SEG_ACTIVE_LOW);

    seg7_t w_glyph_al;
    seg7_t w_glyph;
    seg7_t r_seg_a;
    seg7_t r_seg_b;

    hex7seg_lut u_lut (
        .i_hex    (hex),
        .o_seg_al (w_glyph_al)
    );

    assign w_glyph = to_polarity(w_glyph_al, SEG_ACTIVE_LOW);

    // Separate registers per digit so each pad driver gets its own flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_a <= c_blank;
            r_seg_b <= c_blank;
        end else begin
            r_seg_a <= w_glyph;
            r_seg_b <= w_glyph;
        end
    end

    assign seg_a = r_seg_a;
    assign seg_b = r_seg_b;

endmodule : hex2seg_dual

`default_nettype wire

// File: tb/tb_hex2seg_dual.sv
//==============================================================================
// Module      : tb_hex2seg_dual
// Description : Self-checking bench for hex2seg_dual, both segment polarities.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_hex2seg_dual;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] hex = 4'h0;
    logic [6:0] seg_a, seg_b;
    logic [6:0] ah_seg_a, ah_seg_b;

    int total = 0;
    int bad   = 0;

    // Reference glyphs, active-low {a..g}
    logic [6:0] ref_al [16];

    always #5 clk = ~clk;

    hex2seg_dual #(.SEG_ACTIVE_LOW(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hex   (hex),
        .seg_a (seg_a),
        .seg_b (seg_b)
    );

    hex2seg_dual #(.SEG_ACTIVE_LOW(1'b0)) dut_ah (
        .clk   (clk),
        .rst_n (rst_n),
        .hex   (hex),
        .seg_a (ah_seg_a),
        .seg_b (ah_seg_b)
    );

    // Present a nibble between edges, then land just after the capturing edge
    task automatic step(input logic [3:0] h);
        @(negedge clk);
        hex = h;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        hex = 4'(($urandom));
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (seg_a !== 7'b1111111 || seg_b !== 7'b1111111) begin
            bad++;
            $display("FAIL reset_async_al: seg_a=%b seg_b=%b required=1111111", seg_a, seg_b);
        end
        total++;
        if (ah_seg_a !== 7'b0000000 || ah_seg_b !== 7'b0000000) begin
            bad++;
            $display("FAIL reset_async_ah: seg_a=%b seg_b=%b required=0000000", ah_seg_a, ah_seg_b);
        end
        @(posedge clk);
        #1;
        total++;
        if (seg_a !== 7'b1111111 || seg_b !== 7'b1111111) begin
            bad++;
            $display("FAIL reset_held: seg_a=%b seg_b=%b required=1111111", seg_a, seg_b);
        end
    endtask

    task automatic test_directed();
        logic [3:0] seq [6];
        logic [6:0] want [6];
        seq  = '{4'h0, 4'h1, 4'h2, 4'h3, 4'hB, 4'hF};
        want = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1100000, 7'b0111000};
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(seq[i]);
            total++;
            if (seg_a !== want[i] || seg_b !== want[i]) begin
                bad++;
                $display("FAIL directed_hex%h: seg_a=%b seg_b=%b required=%b",
                         seq[i], seg_a, seg_b, want[i]);
            end
        end
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 16; i++) begin
            step(4'(i));
            total++;
            if (seg_a !== ref_al[i] || seg_b !== ref_al[i]) begin
                bad++;
                $display("FAIL sweep_al_%h: seg_a=%b seg_b=%b required=%b", i, seg_a, seg_b, ref_al[i]);
            end
            total++;
            if (ah_seg_a !== ~ref_al[i] || ah_seg_b !== ~ref_al[i]) begin
                bad++;
                $display("FAIL sweep_ah_%h: seg_a=%b seg_b=%b required=%b", i, ah_seg_a, ah_seg_b, ~ref_al[i]);
            end
        end
    endtask

    // Back-to-back random nibbles; also checks outputs hold the previous glyph before the edge
    task automatic test_back_to_back();
        logic [3:0] prev;
        logic [3:0] h;
        prev = hex;
        for (int n = 0; n < 200; n++) begin
            h = 4'($urandom_range(0, 15));
            @(negedge clk);
            hex = h;
            #1;
            total++;
            if (seg_a !== ref_al[prev]) begin
                bad++;
                $display("FAIL rand_hold_%0d: seg_a=%b required=%b", n, seg_a, ref_al[prev]);
            end
            @(posedge clk);
            #1;
            total++;
            if (seg_a !== ref_al[h] || seg_b !== seg_a || ah_seg_a !== ~ref_al[h] || ah_seg_b !== ah_seg_a) begin
                bad++;
                $display("FAIL rand_%0d hex=%h: al=%b/%b ah=%b/%b required al=%b ah=%b",
                         n, h, seg_a, seg_b, ah_seg_a, ah_seg_b, ref_al[h], ~ref_al[h]);
            end
            prev = h;
        end
    endtask

    task automatic test_mid_reset();
        step(4'h8);
        total++;
        if (seg_a !== 7'b0000000 || seg_b !== 7'b0000000) begin
            bad++;
            $display("FAIL midrst_pre: seg_a=%b seg_b=%b required=0000000", seg_a, seg_b);
        end
        #1;
        hex   = 4'h3;
        rst_n = 1'b0;
        #1;
        total++;
        if (seg_a !== 7'b1111111 || seg_b !== 7'b1111111) begin
            bad++;
            $display("FAIL midrst_async: seg_a=%b seg_b=%b required=1111111", seg_a, seg_b);
        end
        total++;
        if (ah_seg_a !== 7'b0000000 || ah_seg_b !== 7'b0000000) begin
            bad++;
            $display("FAIL midrst_async_ah: seg_a=%b seg_b=%b required=0000000", ah_seg_a, ah_seg_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        hex   = 4'h8;
        @(posedge clk);
        #1;
        total++;
        if (seg_a !== 7'b0000000 || seg_b !== 7'b0000000) begin
            bad++;
            $display("FAIL midrst_release: seg_a=%b seg_b=%b required=0000000", seg_a, seg_b);
        end
    endtask

    task automatic test_active_high();
        step(4'h1);
        total++;
        if (ah_seg_a !== 7'b0110000 || ah_seg_b !== 7'b0110000) begin
            bad++;
            $display("FAIL ah_hex1: seg_a=%b seg_b=%b required=0110000", ah_seg_a, ah_seg_b);
        end
    endtask

    initial begin
        ref_al = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                   7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                   7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                   7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        test_reset();
        test_directed();
        test_sweep();
        test_back_to_back();
        test_mid_reset();
        test_active_high();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_hex2seg_dual

`default_nettype wire
